regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 36 +++
 rtl/regfile_wb_arbiter_scoreboard.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: widths, requester indices and round-robin pick.
// Used by regfile_wb_arbiter and wb_scoreboard (optional block enabled by REGFILE_SCOREBOARD_EN).
package regfile_wb_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;
    localparam int unsigned REQ_MUL = 2;

    typedef logic [1:0] req_idx_t;

    typedef struct packed {
        logic     hit;
        req_idx_t idx;
    } grant_t;

    // Search starts one past the last winner and wraps modulo NUM_REQ.
    function automatic grant_t rr_pick(input logic [NUM_REQ-1:0] valid, input req_idx_t ptr);
        grant_t   g;
        req_idx_t cand;
        g.hit = 1'b0;
        g.idx = ptr;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = req_idx_t'((32'(ptr) + k) % NUM_REQ);
            if (!g.hit && valid[cand]) begin
                g.hit = 1'b1;
                g.idx = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// wb_scoreboard: per-register busy bits set on issue, cleared on a presented writeback.
// Instantiated by regfile_wb_arbiter only when REGFILE_SCOREBOARD_EN is defined.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  hazard1,
    output logic                  hazard2
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // Clear is applied first so a same-cycle set on the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard1 = busy[chk_addr1];
    assign hazard2 = busy[chk_addr2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Three-way round-robin writeback arbiter driving a registered register-file write port.
// Define REGFILE_SCOREBOARD_EN to build the busy-register scoreboard; otherwise hazards read 0.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic                          issue_valid,
    input  logic [ADDR_WIDTH-1:0]         issue_addr,
    input  logic [ADDR_WIDTH-1:0]         chk_addr1,
    input  logic [ADDR_WIDTH-1:0]         chk_addr2,
    output logic                          hazard1,
    output logic                          hazard2
);

    localparam req_idx_t PTR_RESET = req_idx_t'(REQ_MUL);

    req_idx_t              ptr;
    grant_t                grant;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        grant     = rr_pick(req_valid, ptr);
        req_ready = '0;
        if (!rst && grant.hit) begin
            req_ready[grant.idx] = 1'b1;
        end
    end

    assign xfer     = |req_ready;
    assign sel_addr = req_addr[grant.idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data = req_data[grant.idx*DATA_WIDTH +: DATA_WIDTH];

    // Writes to register 0 are accepted and rotate priority but never reach the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= PTR_RESET;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer) begin
            ptr    <= grant.idx;
            rf_wen <= (sel_addr != '0);
            if (sel_addr != '0) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end else begin
            rf_wen <= 1'b0;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue_valid),
        .set_addr  (issue_addr),
        .clr_en    (rf_wen),
        .clr_addr  (rf_waddr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_addr, chk_addr1, chk_addr2};
    assign hazard1 = 1'b0;
    assign hazard2 = 1'b0;
`endif

endmodule
